// File: rtl/wash_cycle_ctrl.sv
// Timed wash-program sequencer: latches a program code, then runs FILL/WASH/RINSE/SPIN.
// Optional freeze input enabled by defining WASH_CYCLE_PAUSE_EN.
module wash_cycle_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int QFILL    = 2,
    parameter int QWASH    = 4,
    parameter int QRINSE   = 2,
    parameter int QSPIN    = 2,
    parameter int FFILL    = 3,
    parameter int FWASH    = 8,
    parameter int FRINSE   = 4,
    parameter int FSPIN    = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Enable,
    input  logic [3:0] Mode,
`ifdef WASH_CYCLE_PAUSE_EN
    input  logic       Pause,
`endif
    output logic       isRunning,
    output logic [2:0] Phase,
    output logic [7:0] TimeLeft,
    output logic       Done
);

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_FILL  = 3'd1;
    localparam logic [2:0] PH_WASH  = 3'd2;
    localparam logic [2:0] PH_RINSE = 3'd3;
    localparam logic [2:0] PH_SPIN  = 3'd4;
    localparam logic [2:0] PH_DONE  = 3'd5;

    localparam int            CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_MAX = CW'(TICK_DIV - 1);

    logic [2:0]    phase_reg, phase_next;
    logic [7:0]    time_left_reg, time_left_next;
    logic [CW-1:0] tick_cnt_reg, tick_cnt_next;
    logic          prog_full_reg, prog_full_next;

    logic tick;
    logic start_req;
    logic pause_act;
    logic unused_mode0;

    // Mode[0] is the selector's echo of our own run flag and carries no program information.
    assign unused_mode0 = Mode[0];

`ifdef WASH_CYCLE_PAUSE_EN
    assign pause_act = Pause;
`else
    assign pause_act = 1'b0;
`endif

    assign tick      = (tick_cnt_reg == TICK_MAX);
    assign start_req = (Mode[3:1] == 3'b001) || (Mode[3:1] == 3'b101);

    function automatic logic [7:0] dur_of(input logic [2:0] ph, input logic full);
        logic [7:0] d;
        d = 8'd0;
        case (ph)
            PH_FILL:  d = full ? 8'(FFILL)  : 8'(QFILL);
            PH_WASH:  d = full ? 8'(FWASH)  : 8'(QWASH);
            PH_RINSE: d = full ? 8'(FRINSE) : 8'(QRINSE);
            PH_SPIN:  d = full ? 8'(FSPIN)  : 8'(QSPIN);
            default:  d = 8'd0;
        endcase
        return d;
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) begin
            phase_reg     <= PH_IDLE;
            time_left_reg <= 8'd0;
            tick_cnt_reg  <= '0;
            prog_full_reg <= 1'b0;
        end else begin
            phase_reg     <= phase_next;
            time_left_reg <= time_left_next;
            tick_cnt_reg  <= tick_cnt_next;
            prog_full_reg <= prog_full_next;
        end
    end

    always_comb begin
        phase_next     = phase_reg;
        time_left_next = time_left_reg;
        tick_cnt_next  = tick_cnt_reg;
        prog_full_next = prog_full_reg;
        if (!Enable) begin
            phase_next     = PH_IDLE;
            time_left_next = 8'd0;
            tick_cnt_next  = '0;
        end else begin
            case (phase_reg)
                PH_IDLE: begin
                    if (start_req) begin
                        prog_full_next = Mode[3];
                        phase_next     = PH_FILL;
                        time_left_next = dur_of(PH_FILL, Mode[3]);
                        tick_cnt_next  = '0;
                    end
                end
                PH_FILL, PH_WASH, PH_RINSE, PH_SPIN: begin
                    if (!pause_act) begin
                        tick_cnt_next = tick ? '0 : tick_cnt_reg + CW'(1);
                        if (tick) begin
                            if (time_left_reg > 8'd1) begin
                                time_left_next = time_left_reg - 8'd1;
                            end else begin
                                // Encoding is sequential, so SPIN + 1 lands on DONE (duration 0).
                                phase_next     = phase_reg + 3'd1;
                                time_left_next = dur_of(phase_reg + 3'd1, prog_full_reg);
                            end
                        end
                    end
                end
                default: begin
                    phase_next     = PH_IDLE;
                    time_left_next = 8'd0;
                    tick_cnt_next  = '0;
                end
            endcase
        end
    end

    always_comb begin
        Phase     = phase_reg;
        TimeLeft  = time_left_reg;
        isRunning = (phase_reg >= PH_FILL) && (phase_reg <= PH_SPIN);
        Done      = (phase_reg == PH_DONE);
    end

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Directed bench for wash_cycle_ctrl at TICK_DIV=4: vector table plus multi-cycle run sequences.
module tb_wash_cycle_ctrl;

    localparam int TD = 4;

    logic       clk;
    logic       srst;
    logic       enable;
    logic [3:0] mode_in;
    logic       pause;
    logic       is_running;
    logic [2:0] phase;
    logic [7:0] time_left;
    logic       done;

    int checks;
    int errors;

    wash_cycle_ctrl #(.TICK_DIV(TD)) dut (
        .Clock    (clk),
        .Reset    (srst),
        .Enable   (enable),
        .Mode     (mode_in),
`ifdef WASH_CYCLE_PAUSE_EN
        .Pause    (pause),
`endif
        .isRunning(is_running),
        .Phase    (phase),
        .TimeLeft (time_left),
        .Done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       en;
        logic [3:0] md;
        logic [2:0] ph;
        logic       run;
        logic [7:0] tl;
        logic       dn;
    } vec_t;

    vec_t vecs[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [2:0] ph, input logic run,
                       input logic [7:0] tl, input logic dn);
        checks++;
        if (phase !== ph || is_running !== run || time_left !== tl || done !== dn) begin
            errors++;
            $display("FAIL %s: got phase=%0d run=%0b tl=%0d done=%0b, want phase=%0d run=%0b tl=%0d done=%0b",
                     name, phase, is_running, time_left, done, ph, run, tl, dn);
        end
    endtask

    // Runs one program from IDLE, checking every cycle against durations; optional Mode glitch and pause.
    task automatic run_check(input string name, input logic [3:0] md, input int d0, input int d1,
                             input int d2, input int d3, input bit glitch, input int p, input int plen);
        int d[4];
        int b[5];
        int tend, te, idx;
        logic [2:0] eph;
        logic       erun, edn;
        logic [7:0] etl;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        b[0] = 0;
        for (int i = 0; i < 4; i++) b[i+1] = b[i] + d[i] * TD;
        tend = b[4] + plen + 2;
        for (int t = 0; t <= tend; t++) begin
            mode_in = (glitch && t >= 5 && t < 20) ? 4'b0011 : md;
            enable  = 1'b1;
            pause   = (plen > 0) && (t > p) && (t <= p + plen);
            step();
            te = (t <= p) ? t : ((t <= p + plen) ? p : t - plen);
            if (te < b[4]) begin
                idx = 0;
                for (int i = 1; i < 4; i++) if (te >= b[i]) idx = i;
                eph = 3'(idx + 1); erun = 1'b1; edn = 1'b0;
                etl = 8'(d[idx] - (te - b[idx]) / TD);
            end else if (te == b[4]) begin
                eph = 3'd5; erun = 1'b0; etl = 8'd0; edn = 1'b1;
            end else if (te == b[4] + 1) begin
                eph = 3'd0; erun = 1'b0; etl = 8'd0; edn = 1'b0;
            end else begin
                eph = 3'd1; erun = 1'b1; etl = 8'(d[0]); edn = 1'b0;
            end
            chk($sformatf("%s_t%0d", name, t), eph, erun, etl, edn);
        end
        pause  = 1'b0;
        enable = 1'b0;
        step();
        chk($sformatf("%s_abort_after", name), 3'd0, 1'b0, 8'd0, 1'b0);
        $display("seq %s: done through t=%0d", name, tend);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        srst    = 1'b1;
        enable  = 1'b0;
        mode_in = 4'b0000;
        pause   = 1'b0;

        vecs[0]  = '{"reset",          1, 1, 4'b0010, 3'd0, 0, 8'd0, 0};
        vecs[1]  = '{"code000",        0, 1, 4'b0001, 3'd0, 0, 8'd0, 0};
        vecs[2]  = '{"code010",        0, 1, 4'b0100, 3'd0, 0, 8'd0, 0};
        vecs[3]  = '{"code111",        0, 1, 4'b1111, 3'd0, 0, 8'd0, 0};
        vecs[4]  = '{"enable_low",     0, 0, 4'b0010, 3'd0, 0, 8'd0, 0};
        vecs[5]  = '{"start_quick",    0, 1, 4'b0011, 3'd1, 1, 8'd2, 0};
        vecs[6]  = '{"abort_fill",     0, 0, 4'b0011, 3'd0, 0, 8'd0, 0};
        vecs[7]  = '{"start_full",     0, 1, 4'b1010, 3'd1, 1, 8'd3, 0};
        vecs[8]  = '{"mode_ignored",   0, 1, 4'b0010, 3'd1, 1, 8'd3, 0};
        vecs[9]  = '{"reset_midrun",   1, 1, 4'b0010, 3'd0, 0, 8'd0, 0};
        vecs[10] = '{"reset_held",     1, 1, 4'b0010, 3'd0, 0, 8'd0, 0};
        vecs[11] = '{"start_post_rst", 0, 1, 4'b0010, 3'd1, 1, 8'd2, 0};
        vecs[12] = '{"abort_clear",    0, 0, 4'b0000, 3'd0, 0, 8'd0, 0};

        for (int i = 0; i < 13; i++) begin
            srst    = vecs[i].rst;
            enable  = vecs[i].en;
            mode_in = vecs[i].md;
            step();
            chk(vecs[i].name, vecs[i].ph, vecs[i].run, vecs[i].tl, vecs[i].dn);
            $display("vec %0d %s: phase=%0d run=%0b tl=%0d done=%0b", i, vecs[i].name,
                     phase, is_running, time_left, done);
        end

        // 20 idle cycles on an invalid code
        for (int i = 0; i < 20; i++) begin
            enable  = 1'b1;
            mode_in = (i < 7) ? 4'b0000 : ((i < 14) ? 4'b0101 : 4'b1110);
            step();
            chk($sformatf("invalid_idle_%0d", i), 3'd0, 1'b0, 8'd0, 1'b0);
        end
        $display("seq invalid_codes: 20 cycles");

        run_check("quick", 4'b0010, 2, 4, 2, 2, 1'b0, 0, 0);
        run_check("full",  4'b1010, 3, 8, 4, 4, 1'b1, 0, 0);

        // Enable dropped in WASH, restart on the following edge
        enable = 1'b1; mode_in = 4'b0010;
        step();
        chk("wash_abort_start", 3'd1, 1'b1, 8'd2, 1'b0);
        for (int i = 0; i < 10; i++) step();
        chk("wash_abort_inwash", 3'd2, 1'b1, 8'd4, 1'b0);
        enable = 1'b0;
        step();
        chk("wash_abort_idle", 3'd0, 1'b0, 8'd0, 1'b0);
        enable = 1'b1;
        step();
        chk("wash_abort_restart", 3'd1, 1'b1, 8'd2, 1'b0);
        enable = 1'b0;
        step();
        $display("seq wash_abort: done");

        // Reset in RINSE (full program: RINSE starts at +44)
        enable = 1'b1; mode_in = 4'b1010;
        step();
        for (int i = 0; i < 46; i++) step();
        chk("rinse_before_reset", 3'd3, 1'b1, 8'd4, 1'b0);
        srst = 1'b1;
        step();
        chk("rinse_reset", 3'd0, 1'b0, 8'd0, 1'b0);
        step();
        chk("rinse_reset_held", 3'd0, 1'b0, 8'd0, 1'b0);
        srst = 1'b0;
        step();
        chk("rinse_reset_release", 3'd1, 1'b1, 8'd3, 1'b0);
        enable = 1'b0;
        step();
        $display("seq rinse_reset: done");

`ifdef WASH_CYCLE_PAUSE_EN
        run_check("pause", 4'b0010, 2, 4, 2, 2, 1'b0, 12, 10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
